pmem_line_responder: RTL and testbench

- Synthesizable responder for the cache-line physical-memory interface (pmem_*), driven by the L1 cache in mp3.
- Stores DEPTH 256-bit lines and answers each read or write with a single-cycle pmem_resp after a fixed, parameterized latency.
- Used as the memory model in cache and CPU benches, and as a block-RAM backed memory on FPGA builds.

---
 rtl/pmem_line_responder_if.sv | 46 ++++
 rtl/pmem_line_responder.sv | 183 ++++++++++++++++++
 tb/tb_pmem_line_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_line_responder_if.sv
// ---------------------------------------------------------------------------
// pmem_line_responder_if
//
// Cache-line physical-memory bus between the L1 cache (master) and a line
// memory (slave). One request is outstanding at a time. The master holds
// pmem_read or pmem_write, together with the address and data, until it
// sees the one-cycle pmem_resp pulse.
//
// Signals:
//   pmem_read     master -> slave  read request
//   pmem_write    master -> slave  write request
//   pmem_address  master -> slave  byte address (bits [4:0] ignored)
//   pmem_wdata    master -> slave  256-bit write line
//   pmem_rdata    slave  -> master 256-bit read line, valid with pmem_resp
//   pmem_resp     slave  -> master one-cycle completion pulse
//   pmem_busy     slave  -> master transaction in flight
// ---------------------------------------------------------------------------
interface pmem_line_responder_if;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         pmem_busy;

    modport master (
        output pmem_read,
        output pmem_write,
        output pmem_address,
        output pmem_wdata,
        input  pmem_rdata,
        input  pmem_resp,
        input  pmem_busy
    );

    modport slave (
        input  pmem_read,
        input  pmem_write,
        input  pmem_address,
        input  pmem_wdata,
        output pmem_rdata,
        output pmem_resp,
        output pmem_busy
    );
endinterface

// File: rtl/pmem_line_responder.sv
// ---------------------------------------------------------------------------
// pmem_line_responder
//
// Line memory that answers the L1 cache pmem_* bus. It stores DEPTH lines of
// 256 bits and completes every read or write with a single-cycle pmem_resp,
// LATENCY cycles after the request first appears. Serves as the memory model
// in cache/CPU benches and as block-RAM backed memory on FPGA builds.
//
// Parameters:
//   LATENCY  request-to-response delay in cycles, 1..15
//   DEPTH    number of stored lines, power of 2
//   IDX_W    line index width, derived from DEPTH
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   bus             pmem_line_responder_if.slave (read/write/address/wdata in,
//                   rdata/resp/busy out)
//   pmem_proto_err  sticky protocol-violation flag (only when
//                   PMEM_PROTO_CHECK_EN is defined)
//
// Optional feature macro: PMEM_PROTO_CHECK_EN
//   Defined   -> adds pmem_proto_err and the bus protocol checker.
//   Undefined -> no extra port, no checker; datapath behaviour identical.
//
// The command, index and write data are all sampled on the edge that moves
// the FSM into RESP, not when the request first appears. A master that
// changes its request mid-wait therefore gets the later values.
// ---------------------------------------------------------------------------
module pmem_line_responder #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 256,
    parameter int IDX_W   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pmem_line_responder_if.slave  bus
`ifdef PMEM_PROTO_CHECK_EN
    ,
    output logic                  pmem_proto_err
`endif
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic               req;
    logic               enter_resp;
    logic [IDX_W-1:0]   idx;
    logic [255:0]       rdata_q;
    logic [255:0]       mem [DEPTH];

    // Address bits outside the line index never affect behaviour.
    logic               unused_addr_bits;
    assign unused_addr_bits = ^{bus.pmem_address[31:5+IDX_W], bus.pmem_address[4:0]};

    assign req = bus.pmem_read | bus.pmem_write;
    assign idx = bus.pmem_address[5 +: IDX_W];

    // ---- FSM state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---- FSM next state ----
    // WAIT is entered with LATENCY-1 and left when the count reaches 1,
    // so RESP lands exactly LATENCY cycles after the request cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The single edge on which the memory is accessed. Qualified by rst_n
    // so an edge that arrives while reset is held cannot write the array.
    assign enter_resp = rst_n && (state_d == RESP) && (state_q != RESP);

    // ---- Memory access at RESP entry ----
    // Line storage is not reset, which keeps it mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (enter_resp && bus.pmem_write) begin
            mem[idx] <= bus.pmem_wdata;
        end
    end

    // Write has priority: a combined read+write does not touch rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (enter_resp && bus.pmem_read && !bus.pmem_write) begin
            rdata_q <= mem[idx];
        end
    end

    assign bus.pmem_rdata = rdata_q;
    assign bus.pmem_resp  = (state_q == RESP);
    assign bus.pmem_busy  = (state_q != IDLE);

`ifdef PMEM_PROTO_CHECK_EN
    // ---- Protocol checker ----
    // Previous-cycle copies of the request. They are only compared while in
    // WAIT, which always follows a cycle that loaded them, so they need no
    // reset; only the sticky flag is reset.
    logic [31:0]   addr_prev;
    logic          rd_prev;
    logic          wr_prev;
    logic [255:0]  wdata_prev;
    logic          err_q;
    logic          both_cmds;
    logic          wait_change;
    logic          proto_viol;

    always_ff @(posedge clk) begin
        addr_prev  <= bus.pmem_address;
        rd_prev    <= bus.pmem_read;
        wr_prev    <= bus.pmem_write;
        wdata_prev <= bus.pmem_wdata;
    end

    // A request is sampled when IDLE accepts it and again at RESP entry.
    assign both_cmds = bus.pmem_read && bus.pmem_write &&
                       (((state_q == IDLE) && req) || enter_resp);

    assign wait_change = (state_q == WAIT) &&
                         ((bus.pmem_address != addr_prev) ||
                          (bus.pmem_read    != rd_prev)   ||
                          (bus.pmem_write   != wr_prev)   ||
                          (wr_prev && (bus.pmem_wdata != wdata_prev)));

    assign proto_viol = both_cmds || wait_change;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (proto_viol) begin
            err_q <= 1'b1;
        end
    end

    assign pmem_proto_err = err_q;
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// ---------------------------------------------------------------------------
// tb_pmem_line_responder
//
// Directed bench for pmem_line_responder. dut0 (LATENCY=4) is driven by
// issue(); each call queues its expected response cycle and read data, and
// an independent monitor pops and checks on every pmem_resp. dut1
// (LATENCY=1) checks back-to-back throughput with a held read.
// ---------------------------------------------------------------------------
module tb_pmem_line_responder;

    localparam int L0 = 4;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_pass;
    int   n_total;
    int   step;

    typedef struct {
        int           cyc;
        logic [255:0] rdata;
        int           id;
    } exp_t;

    exp_t sb[$];

    pmem_line_responder_if if0 ();
    pmem_line_responder_if if1 ();

`ifdef PMEM_PROTO_CHECK_EN
    logic err0;
    logic err1;
`endif

    pmem_line_responder #(.LATENCY(L0), .DEPTH(256)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
`ifdef PMEM_PROTO_CHECK_EN
        ,
        .pmem_proto_err (err0)
`endif
    );

    pmem_line_responder #(.LATENCY(1), .DEPTH(256)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
`ifdef PMEM_PROTO_CHECK_EN
        ,
        .pmem_proto_err (err1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Scoreboard monitor: every pmem_resp must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if0.pmem_resp === 1'b1) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_resp at cycle %0d actual=1 required=0", cyc);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("step%0d_resp_cycle", e.id), 256'(cyc), 256'(e.cyc));
                    check($sformatf("step%0d_rdata", e.id), if0.pmem_rdata, e.rdata);
                    check($sformatf("step%0d_busy_in_resp", e.id), 256'(if0.pmem_busy), 256'(1));
                end
            end
        end
    end

    // mode 0: hold until resp; mode 1: switch to addr2/wd2 in the second
    // WAIT cycle; mode 2: drop the command in the first WAIT cycle.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] wd, input logic [255:0] exp_rd,
                         input int mode, input logic [31:0] addr2, input logic [255:0] wd2);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        step++;
        @(negedge clk);
        if0.pmem_read    = rd;
        if0.pmem_write   = wr;
        if0.pmem_address = addr;
        if0.pmem_wdata   = wd;
        e.cyc   = cyc + L0;
        e.rdata = exp_rd;
        e.id    = step;
        sb.push_back(e);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (if0.pmem_resp === 1'b1) begin
                seen = 1'b1;
                if0.pmem_read  = 1'b0;
                if0.pmem_write = 1'b0;
            end else if (mode == 1 && i == 1) begin
                if0.pmem_address = addr2;
                if0.pmem_wdata   = wd2;
            end else if (mode == 2 && i == 0) begin
                if0.pmem_read  = 1'b0;
                if0.pmem_write = 1'b0;
            end
        end
        if (!seen) begin
            n_total++;
            $display("FAIL step%0d_resp_timeout actual=none required=resp", step);
            if0.pmem_read  = 1'b0;
            if0.pmem_write = 1'b0;
        end
    endtask

    initial begin
        logic [255:0] A5, P1, P2, P3, P4, P5, Z;
        A5 = {32{8'hA5}};
        P1 = {8{32'hDEADBEEF}};
        P2 = {16{16'h5A3C}};
        P3 = {4{64'h0123456789ABCDEF}};
        P4 = {8{32'hCAFEF00D}};
        P5 = {8{32'h13579BDF}};
        Z  = '0;
        cyc = 0; n_pass = 0; n_total = 0; step = 0;
        rst_n = 1'b0;
        if0.pmem_read = 1'b0; if0.pmem_write = 1'b0;
        if0.pmem_address = '0; if0.pmem_wdata = '0;
        if1.pmem_read = 1'b0; if1.pmem_write = 1'b0;
        if1.pmem_address = '0; if1.pmem_wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_rdata", if0.pmem_rdata, Z);
        check("reset_resp", 256'(if0.pmem_resp), 256'(0));
        check("reset_busy", 256'(if0.pmem_busy), 256'(0));
`ifdef PMEM_PROTO_CHECK_EN
        check("reset_err", 256'(err0), 256'(0));
`endif

        // write line 2 then read it back
        issue(1'b0, 1'b1, 32'h0000_0040, A5, Z, 0, 32'h0, Z);
        issue(1'b1, 1'b0, 32'h0000_0040, Z, A5, 0, 32'h0, Z);
        // 0x2000 aliases to line 0; low address bits ignored
        issue(1'b0, 1'b1, 32'h0000_2000, P1, A5, 0, 32'h0, Z);
        issue(1'b1, 1'b0, 32'h0000_001F, Z, P1, 0, 32'h0, Z);
        // read+write: write wins, rdata unchanged
        issue(1'b1, 1'b1, 32'h0000_0080, 256'h1234, P1, 0, 32'h0, Z);
`ifdef PMEM_PROTO_CHECK_EN
        check("rw_both_err", 256'(err0), 256'(1));
`endif
        issue(1'b1, 1'b0, 32'h0000_0080, Z, 256'h1234, 0, 32'h0, Z);
`ifdef PMEM_PROTO_CHECK_EN
        check("err_sticky", 256'(err0), 256'(1));
`endif

        // reset in the middle of a write to line 5
        issue(1'b0, 1'b1, 32'h0000_00A0, P2, 256'h1234, 0, 32'h0, Z);
        @(negedge clk);
        if0.pmem_write = 1'b1; if0.pmem_address = 32'h0000_00A0; if0.pmem_wdata = P3;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        if0.pmem_write = 1'b0;
        #1;
        check("midreset_resp", 256'(if0.pmem_resp), 256'(0));
        check("midreset_busy", 256'(if0.pmem_busy), 256'(0));
        check("midreset_rdata", if0.pmem_rdata, Z);
`ifdef PMEM_PROTO_CHECK_EN
        check("midreset_err", 256'(err0), 256'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(1'b1, 1'b0, 32'h0000_00A0, Z, P2, 0, 32'h0, Z);

        // address switched mid-wait: completes on the new address
        issue(1'b0, 1'b1, 32'h0000_0100, P5, P2, 0, 32'h0, Z);
`ifdef PMEM_PROTO_CHECK_EN
        check("clean_err", 256'(err0), 256'(0));
`endif
        issue(1'b0, 1'b1, 32'h0000_0100, P5, P2, 1, 32'h0000_0120, P4);
`ifdef PMEM_PROTO_CHECK_EN
        check("addr_change_err", 256'(err0), 256'(1));
`endif
        issue(1'b1, 1'b0, 32'h0000_0120, Z, P4, 0, 32'h0, Z);
        issue(1'b1, 1'b0, 32'h0000_0100, Z, P5, 0, 32'h0, Z);
        // command dropped mid-wait: resp still pulses, no access
        issue(1'b1, 1'b0, 32'h0000_0040, Z, P5, 2, 32'h0, Z);
        issue(1'b1, 1'b0, 32'h0000_0040, Z, A5, 0, 32'h0, Z);

        // LATENCY=1 with a held read: resp every other cycle, busy == resp
        @(negedge clk);
        if1.pmem_read = 1'b1;
        if1.pmem_address = 32'h0000_0000;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("l1_resp_k%0d", k), 256'(if1.pmem_resp), 256'(k % 2));
            check($sformatf("l1_busy_k%0d", k), 256'(if1.pmem_busy), 256'(k % 2));
        end
        if1.pmem_read = 1'b0;

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
